// File: rtl/sdhci_sdma_obi.sv
// Single-channel SDMA engine: moves 32-bit words between the card FIFOs and
// system memory through an OBI manager port, pausing at SDMA buffer boundaries.
module sdhci_sdma_obi #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned BoundaryBytes = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 dir_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [15:0]          num_words_i,
   input  logic                 resume_i,
   input  logic                 abort_i,
   input  logic [DataWidth-1:0] rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   output logic [DataWidth-1:0] tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 obi_req_o,
   output logic                 obi_we_o,
   output logic [AddrWidth-1:0] obi_addr_o,
   output logic [3:0]           obi_be_o,
   output logic [DataWidth-1:0] obi_wdata_o,
   input  logic                 obi_gnt_i,
   input  logic                 obi_rvalid_i,
   input  logic                 obi_err_i,
   input  logic [DataWidth-1:0] obi_rdata_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic                 boundary_o
);

   localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(3);
   localparam logic [AddrWidth-1:0] BoundMask = AddrWidth'(BoundaryBytes - 1);

   typedef enum logic [2:0] {IDLE, FETCH, REQ, RESP, PUSH, PAUSE} state_e;

   state_e               state_q, state_d, xfer_state;
   logic [AddrWidth-1:0] addr_q, next_addr;
   logic [15:0]          count_q;
   logic                 dir_q, abort_q;
   logic [DataWidth-1:0] wdata_q, rdata_q;
   logic                 done_q, error_q, boundary_q;
   logic                 done_d, error_d, boundary_d;
   logic                 latch_start, reload, cap_rx, cap_rd, word_done, set_abort;

   assign next_addr  = addr_q + AddrWidth'(4);
   assign xfer_state = dir_q ? FETCH : REQ;

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      boundary_d  = 1'b0;
      latch_start = 1'b0;
      reload      = 1'b0;
      cap_rx      = 1'b0;
      cap_rd      = 1'b0;
      word_done   = 1'b0;
      set_abort   = 1'b0;
      unique case (state_q)
         IDLE: if (start_i) begin
            latch_start = 1'b1;
            if (num_words_i == 16'd0) done_d  = 1'b1;
            else                      state_d = dir_i ? FETCH : REQ;
         end
         FETCH: begin
            if (abort_i) state_d = IDLE;
            else if (rx_valid_i) begin
               cap_rx  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            // A request on the bus cannot be withdrawn, so an abort is only remembered here.
            set_abort = abort_i;
            if (obi_gnt_i) state_d = RESP;
         end
         RESP: begin
            set_abort = abort_i;
            if (obi_rvalid_i) begin
               if (obi_err_i) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end else if (abort_i || abort_q) begin
                  state_d = IDLE;
               end else if (!dir_q) begin
                  cap_rd  = 1'b1;
                  state_d = PUSH;
               end else begin
                  word_done = 1'b1;
               end
            end
         end
         PUSH: begin
            if (abort_i)         state_d = IDLE;
            else if (tx_ready_i) word_done = 1'b1;
         end
         PAUSE: begin
            if (abort_i) state_d = IDLE;
            else if (resume_i) begin
               reload  = 1'b1;
               state_d = xfer_state;
            end
         end
         default: state_d = IDLE;
      endcase
      // Completion: done wins over a coinciding boundary.
      if (word_done) begin
         if (count_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end else if ((next_addr & BoundMask) == '0) begin
            boundary_d = 1'b1;
            state_d    = PAUSE;
         end else begin
            state_d = xfer_state;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         dir_q      <= 1'b0;
         abort_q    <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         boundary_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         error_q    <= error_d;
         boundary_q <= boundary_d;
         abort_q    <= (state_d == IDLE) ? 1'b0 : (abort_q | set_abort);
         if (latch_start) begin
            addr_q  <= addr_i & AlignMask;
            count_q <= num_words_i;
            dir_q   <= dir_i;
         end else if (reload) begin
            addr_q <= addr_i & AlignMask;
         end else if (word_done) begin
            addr_q  <= next_addr;
            count_q <= count_q - 16'd1;
         end
         if (cap_rx) wdata_q <= rx_data_i;
         if (cap_rd) rdata_q <= obi_rdata_i;
      end
   end

   assign obi_req_o   = (state_q == REQ);
   assign obi_we_o    = (state_q == REQ) & dir_q;
   assign obi_addr_o  = addr_q;
   assign obi_be_o    = 4'hF;
   assign obi_wdata_o = wdata_q;
   assign rx_ready_o  = (state_q == FETCH);
   assign tx_valid_o  = (state_q == PUSH);
   assign tx_data_o   = rdata_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign boundary_o  = boundary_q;

endmodule

// File: tb/tb_sdhci_sdma_obi.sv
// Scoreboard bench for sdhci_sdma_obi: a transfer-level model predicts OBI
// transactions, TX pushes and status pulses; a negedge monitor checks them.
module tb_sdhci_sdma_obi;

   localparam int unsigned Bound = 4096;

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        start_i = 1'b0, dir_i = 1'b0, resume_i = 1'b0, abort_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [15:0] num_words_i = '0;
   logic [31:0] rx_data_i = '0, tx_data_o, obi_addr_o, obi_wdata_o, obi_rdata_i = '0;
   logic        rx_valid_i = 1'b0, rx_ready_o, tx_valid_o, tx_ready_i = 1'b0;
   logic        obi_req_o, obi_we_o, obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
   logic [3:0]  obi_be_o;
   logic        busy_o, done_o, error_o, boundary_o;

   always #5 clk_i = ~clk_i;

   sdhci_sdma_obi #(.AddrWidth(32), .DataWidth(32), .BoundaryBytes(Bound)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i), .addr_i(addr_i),
      .num_words_i(num_words_i), .resume_i(resume_i), .abort_i(abort_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_addr_o(obi_addr_o),
      .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i),
      .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i), .obi_rdata_i(obi_rdata_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .boundary_o(boundary_o)
   );

   typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } obi_txn_t;
   typedef enum int {EV_DONE = 0, EV_BOUND = 1, EV_ERR = 2} ev_e;

   obi_txn_t    exp_obi[$];
   logic [31:0] exp_tx[$];
   ev_e         exp_ev[$];
   logic [31:0] rx_src[$];

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Transfer-level reference: which words move where, and which pulses follow.
   task automatic plan(input bit dir, input logic [31:0] addr, input int n,
                       input logic [31:0] res, input int err_k, input bit abort_first);
      logic [31:0] a;
      logic [31:0] words[$];
      int          left;
      obi_txn_t    t;
      a    = addr & ~32'd3;
      left = n;
      rx_src.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      if (dir) rx_src = words;
      if (n == 0) begin
         exp_ev.push_back(EV_DONE);
         return;
      end
      for (int k = 0; k < n; k++) begin
         t.addr  = a;
         t.we    = dir;
         t.wdata = dir ? words[k] : 32'd0;
         exp_obi.push_back(t);
         if (k == err_k) begin
            exp_ev.push_back(EV_ERR);
            break;
         end
         if (abort_first) break;
         if (!dir) exp_tx.push_back(mem_word(a));
         a += 32'd4;
         left--;
         if (left == 0) begin
            exp_ev.push_back(EV_DONE);
            break;
         end
         if (a % Bound == 0) begin
            exp_ev.push_back(EV_BOUND);
            a = res & ~32'd3;
         end
      end
   endtask

   // OBI subordinate with configurable grant/response latency and error injection.
   int          gnt_max = 0, rsp_max = 0, gnt_ovr = -1, rsp_ovr = -1, err_at = -1;
   int          txn_no = 0, gnt_wait = -1, rsp_wait = 0;
   bit          rsp_pend = 0, rsp_err = 0;
   logic [31:0] rsp_data = '0;

   always begin
      tick();
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
      if (rst_i) begin
         rsp_pend = 0;
         gnt_wait = -1;
      end else if (rsp_pend) begin
         if (rsp_wait > 0) rsp_wait--;
         else begin
            obi_rvalid_i = 1'b1; obi_err_i = rsp_err; obi_rdata_i = rsp_data; rsp_pend = 0;
         end
      end else if (obi_req_o) begin
         if (gnt_wait < 0) begin
            gnt_wait = (gnt_ovr >= 0) ? gnt_ovr : int'($urandom_range(0, gnt_max));
            gnt_ovr  = -1;
         end
         if (gnt_wait > 0) gnt_wait--;
         else begin
            obi_gnt_i = 1'b1;
            gnt_wait  = -1;
            rsp_pend  = 1;
            rsp_wait  = (rsp_ovr >= 0) ? rsp_ovr : int'($urandom_range(0, rsp_max));
            rsp_ovr   = -1;
            rsp_err   = (txn_no == err_at);
            rsp_data  = mem_word(obi_addr_o);
            txn_no++;
         end
      end
   end

   // Receive FIFO source and transmit FIFO sink.
   bit rx_rand = 0, tx_rand = 0, rx_pop;
   int stall_word = -1, stall_left = 0, tx_cnt = 0;

   always begin
      @(negedge clk_i);
      rx_pop = rx_valid_i && rx_ready_o;
      tick();
      if (rx_pop && rx_src.size() != 0) void'(rx_src.pop_front());
      rx_valid_i = (rx_src.size() != 0) && (!rx_rand || $urandom_range(0, 3) != 0);
      rx_data_i  = (rx_src.size() != 0) ? rx_src[0] : 32'd0;
   end

   always begin
      tick();
      if (tx_valid_o && tx_cnt == stall_word && stall_left > 0) begin
         tx_ready_i = 1'b0;
         stall_left--;
      end else begin
         tx_ready_i = tx_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents something.
   bit       prev_req_wait = 0, bound_seen = 0, end_seen = 0;
   int       busy_cnt = 0;
   obi_txn_t m_t;
   ev_e      m_ev, m_got;

   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_req_wait = 0;
      end else begin
         if (busy_o) busy_cnt++;
         if (prev_req_wait) check("req_hold_until_gnt", 32'(obi_req_o), 32'd1);
         prev_req_wait = obi_req_o && !obi_gnt_i;
         if (obi_req_o && obi_gnt_i) begin
            check("obi_txn_expected", 32'(exp_obi.size() != 0), 32'd1);
            if (exp_obi.size() != 0) begin
               m_t = exp_obi.pop_front();
               check("obi_addr", obi_addr_o, m_t.addr);
               check("obi_we", 32'(obi_we_o), 32'(m_t.we));
               check("obi_be", 32'(obi_be_o), 32'hF);
               if (m_t.we) check("obi_wdata", obi_wdata_o, m_t.wdata);
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            check("tx_push_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) check("tx_data", tx_data_o, exp_tx.pop_front());
            tx_cnt++;
         end else if (tx_valid_o && exp_tx.size() != 0) begin
            check("tx_stall_data", tx_data_o, exp_tx[0]);
            check("tx_stall_no_req", 32'(obi_req_o), 32'd0);
         end
         if (done_o || boundary_o || error_o) begin
            check("single_status_pulse", 32'(done_o) + 32'(boundary_o) + 32'(error_o), 32'd1);
            m_got = done_o ? EV_DONE : (boundary_o ? EV_BOUND : EV_ERR);
            check("status_expected", 32'(exp_ev.size() != 0), 32'd1);
            if (exp_ev.size() != 0) begin
               m_ev = exp_ev.pop_front();
               check("status_kind", 32'(m_got), 32'(m_ev));
            end
            if (boundary_o) bound_seen = 1;
            else            end_seen   = 1;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, 32'(obi_req_o), 0);
      check({tag, "_we"}, 32'(obi_we_o), 0);
      check({tag, "_rx_ready"}, 32'(rx_ready_o), 0);
      check({tag, "_tx_valid"}, 32'(tx_valid_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
      check({tag, "_status"}, {29'd0, done_o, error_o, boundary_o}, 0);
      check({tag, "_addr"}, obi_addr_o, 0);
      check({tag, "_wdata"}, obi_wdata_o, 0);
      check({tag, "_tx_data"}, tx_data_o, 0);
      check({tag, "_be"}, 32'(obi_be_o), 32'hF);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_obi_drained"}, exp_obi.size(), 0);
      check({tag, "_tx_drained"}, exp_tx.size(), 0);
      check({tag, "_status_drained"}, exp_ev.size(), 0);
   endtask

   task automatic pulse_start(input bit dir, input logic [31:0] addr, input int n);
      start_i = 1'b1; dir_i = dir; addr_i = addr; num_words_i = 16'(n);
      tick();
      start_i = 1'b0;
   endtask

   // Run one full transfer, servicing boundary pauses with the given reload address.
   task automatic run(input string tag, input bit dir, input logic [31:0] addr, input int n,
                      input logic [31:0] res, input int err_k);
      int cyc;
      plan(dir, addr, n, res, err_k, 0);
      txn_no = 0; err_at = err_k; end_seen = 0; bound_seen = 0; busy_cnt = 0;
      pulse_start(dir, addr, n);
      cyc = 0;
      while (busy_o && cyc < 4000) begin
         if (bound_seen) begin
            bound_seen = 0;
            repeat ($urandom_range(0, 3)) tick();
            check({tag, "_pause_busy"}, 32'(busy_o), 1);
            check({tag, "_pause_idle_bus"}, 32'(obi_req_o), 0);
            addr_i = res; resume_i = 1'b1;
            tick();
            resume_i = 1'b0;
         end
         tick();
         cyc++;
      end
      check({tag, "_finished_in_budget"}, 32'(cyc < 4000), 1);
      check({tag, "_pulse_with_busy_fall"}, 32'(done_o | error_o), 1);
      repeat (2) tick();
      check_drained(tag);
      err_at = -1;
   endtask

   int          cyc;
   bit          r_dir;
   int          r_n, r_err;
   logic [31:0] r_addr, r_res;

   initial begin
      #3;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      tick();

      // Card to memory, 4 words, zero-latency bus: 3 cycles per word.
      run("c2m_basic", 1'b1, 32'h0000_1000, 4, 32'h0, -1);
      check("c2m_busy_cycles", busy_cnt, 12);

      // Memory to card with a 5-cycle transmit stall on word 2.
      tx_cnt = 0; stall_word = 1; stall_left = 5;
      run("m2c_stall", 1'b0, 32'h0000_4000, 3, 32'h0, -1);
      check("m2c_words_pushed", tx_cnt, 3);
      stall_word = -1;

      // Boundary pause at 0x1000, resume at 0x8000.
      run("boundary", 1'b1, 32'h0000_0FF8, 4, 32'h0000_8000, -1);

      // Bus error on the second word, then a clean transfer.
      run("obi_error", 1'b0, 32'h0000_5000, 4, 32'h0, 1);
      run("after_error", 1'b1, 32'h0000_6000, 3, 32'h0, -1);

      // Abort while the request waits 4 cycles for grant.
      plan(1'b0, 32'h0000_3000, 4, 32'h0, -1, 1);
      txn_no = 0; gnt_ovr = 4;
      pulse_start(1'b0, 32'h0000_3000, 4);
      check("abort_req_raised", 32'(obi_req_o), 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      cyc = 0;
      while (busy_o && cyc < 100) begin tick(); cyc++; end
      check("abort_finished_in_budget", 32'(cyc < 100), 1);
      check("abort_no_done", 32'(done_o), 0);
      repeat (2) tick();
      check_drained("abort");

      // Zero-length transfer: done one cycle after start, no bus traffic.
      plan(1'b1, 32'h0000_7000, 0, 32'h0, -1, 0);
      pulse_start(1'b1, 32'h0000_7000, 0);
      check("zero_done", 32'(done_o), 1);
      check("zero_busy", 32'(busy_o), 0);
      check("zero_no_req", 32'(obi_req_o | rx_ready_o), 0);
      repeat (2) tick();
      check_drained("zero");

      // Asynchronous reset while waiting for a slow response.
      plan(1'b1, 32'h0000_2000, 2, 32'h0, -1, 0);
      txn_no = 0; rsp_ovr = 20;
      pulse_start(1'b1, 32'h0000_2000, 2);
      cyc = 0;
      while (!rsp_pend && cyc < 50) begin tick(); cyc++; end
      check("rst_reached_resp", 32'(rsp_pend), 1);
      tick();
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1 check_reset_outputs("async_rst");
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_obi.delete(); exp_tx.delete(); exp_ev.delete(); rx_src.delete();
      rsp_ovr = -1;
      tick();

      // Randomized transfers under random bus latency and FIFO back-pressure.
      gnt_max = 2; rsp_max = 2; rx_rand = 1; tx_rand = 1;
      for (int it = 0; it < 20; it++) begin
         r_dir = 1'($urandom_range(0, 1));
         r_n   = int'($urandom_range(1, 10));
         if ($urandom_range(0, 1) != 0)
            r_addr = ($urandom & 32'hFFFF_F000) - 32'(4 * $urandom_range(1, 6)) + 32'($urandom_range(0, 3));
         else
            r_addr = $urandom;
         r_res = $urandom;
         r_err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_n - 1)) : -1;
         run("random", r_dir, r_addr, r_n, r_res, r_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
